// File: rtl/uart_pkg.sv
// Shared definitions for the UART transceiver: parity encoding, RX/TX state
// encodings and a frame-length helper.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    // Total bit periods in one frame on the line.
    function automatic int FRAME_BITS(input int width, input int parity, input int stops);
        return 1 + width + ((parity != PARITY_NONE) ? 1 : 0) + stops;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Storage array; no reset needed since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_fifo_transceiver.sv
// Full-duplex UART with run-time baud divisor and buffered receive path.
//
// RX states
//   state     | meaning
//   RX_IDLE   | waiting for a synchronised 0 on the line
//   RX_START  | half-bit wait, then confirm start bit (1 = glitch)
//   RX_DATA   | sampling data bits LSB first, one per div cycles
//   RX_PARITY | sampling and checking the parity bit
//   RX_STOP   | sampling stop bit(s); last one pushes the word
//
// TX states
//   state     | meaning
//   TX_IDLE   | line high, tx_ready high
//   TX_START  | driving start bit for div cycles
//   TX_DATA   | driving data bits LSB first
//   TX_PARITY | driving parity bit
//   TX_STOP   | driving stop bit(s)
module uart_fifo_transceiver
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int STOP_BITS     = 1,
    parameter int PARITY        = 0,
    parameter int DIV_WIDTH     = 16,
    parameter int RX_FIFO_DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DIV_WIDTH-1:0]             baud_div,
    input  logic [DATA_WIDTH-1:0]            tx_data,
    input  logic                             tx_valid,
    output logic                             tx_ready,
    output logic [DATA_WIDTH-1:0]            rx_data,
    output logic                             rx_parity_err,
    output logic                             rx_frame_err,
    output logic                             rx_valid,
    input  logic                             rx_ready,
    output logic                             rx_overflow,
    output logic [$clog2(RX_FIFO_DEPTH):0]   rx_count,
    input  logic                             uart_rx,
    output logic                             uart_tx
);

    localparam int IDX_W  = $clog2(DATA_WIDTH + 1);
    localparam int FIFO_W = DATA_WIDTH + 2;

    // ------------------------------------------------------------------
    // Line synchroniser
    // ------------------------------------------------------------------
    logic sync_0;
    logic sync_1;
    logic rx_s;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_0 <= 1'b1;
            sync_1 <= 1'b1;
        end else begin
            sync_0 <= uart_rx;
            sync_1 <= sync_0;
        end
    end

    assign rx_s = sync_1;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    rx_state_t              rx_state,  rx_state_nxt;
    logic [DIV_WIDTH-1:0]   rx_div,    rx_div_nxt;
    logic [DIV_WIDTH-1:0]   rx_cnt,    rx_cnt_nxt;
    logic [IDX_W-1:0]       rx_idx,    rx_idx_nxt;
    logic [DATA_WIDTH-1:0]  rx_shift,  rx_shift_nxt;
    logic                   rx_perr,   rx_perr_nxt;
    logic                   rx_ferr,   rx_ferr_nxt;
    logic                   rx_push;
    logic                   rx_par_exp;
    logic                   rx_stop_ferr;
    logic [FIFO_W-1:0]      rx_push_word;
    logic [FIFO_W-1:0]      fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign rx_par_exp   = (PARITY == PARITY_EVEN) ? ^rx_shift : ~^rx_shift;
    assign rx_stop_ferr = rx_ferr | ~rx_s;
    assign rx_push_word = {rx_stop_ferr, rx_perr, rx_shift};

    // RX state and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_div   <= '0;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
            rx_perr  <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_div   <= rx_div_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_idx   <= rx_idx_nxt;
            rx_shift <= rx_shift_nxt;
            rx_perr  <= rx_perr_nxt;
            rx_ferr  <= rx_ferr_nxt;
        end
    end

    // RX next state: down-counter reaching zero marks each sample point.
    always_comb begin
        rx_state_nxt = rx_state;
        rx_div_nxt   = rx_div;
        rx_cnt_nxt   = (rx_cnt != '0) ? rx_cnt - 1'b1 : rx_cnt;
        rx_idx_nxt   = rx_idx;
        rx_shift_nxt = rx_shift;
        rx_perr_nxt  = rx_perr;
        rx_ferr_nxt  = rx_ferr;
        rx_push      = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (!rx_s) begin
                    rx_state_nxt = RX_START;
                    rx_div_nxt   = baud_div;
                    rx_cnt_nxt   = (baud_div >> 1) - 1'b1;
                    rx_idx_nxt   = '0;
                    rx_perr_nxt  = 1'b0;
                    rx_ferr_nxt  = 1'b0;
                end
            end
            RX_START: begin
                if (rx_cnt == '0) begin
                    if (rx_s) begin
                        rx_state_nxt = RX_IDLE;
                    end else begin
                        rx_state_nxt = RX_DATA;
                        rx_cnt_nxt   = rx_div - 1'b1;
                        rx_idx_nxt   = '0;
                    end
                end
            end
            RX_DATA: begin
                if (rx_cnt == '0) begin
                    rx_shift_nxt = {rx_s, rx_shift[DATA_WIDTH-1:1]};
                    rx_cnt_nxt   = rx_div - 1'b1;
                    if (rx_idx == IDX_W'(DATA_WIDTH - 1)) begin
                        rx_idx_nxt = '0;
                        if (PARITY != PARITY_NONE) begin
                            rx_state_nxt = RX_PARITY;
                        end else begin
                            rx_state_nxt = RX_STOP;
                        end
                    end else begin
                        rx_idx_nxt = rx_idx + 1'b1;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_cnt == '0) begin
                    rx_perr_nxt  = (rx_s != rx_par_exp);
                    rx_state_nxt = RX_STOP;
                    rx_cnt_nxt   = rx_div - 1'b1;
                    rx_idx_nxt   = '0;
                end
            end
            RX_STOP: begin
                if (rx_cnt == '0) begin
                    rx_ferr_nxt = rx_stop_ferr;
                    if (rx_idx == IDX_W'(STOP_BITS - 1)) begin
                        // Back to IDLE right away so a following start bit is caught.
                        rx_push      = 1'b1;
                        rx_state_nxt = RX_IDLE;
                    end else begin
                        rx_idx_nxt = rx_idx + 1'b1;
                        rx_cnt_nxt = rx_div - 1'b1;
                    end
                end
            end
            default: begin
                rx_state_nxt = RX_IDLE;
            end
        endcase
    end

    uart_sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (RX_FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (rx_push_word),
        .pop       (rx_ready),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (rx_count)
    );

    assign rx_data       = fifo_head[DATA_WIDTH-1:0];
    assign rx_parity_err = fifo_head[DATA_WIDTH];
    assign rx_frame_err  = fifo_head[DATA_WIDTH+1];
    assign rx_valid      = !fifo_empty;
    // A full FIFO only makes room when the head is popped this same cycle.
    assign rx_overflow   = rx_push && fifo_full && !rx_ready && !rst;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_t              tx_state,  tx_state_nxt;
    logic [DIV_WIDTH-1:0]   tx_div,    tx_div_nxt;
    logic [DIV_WIDTH-1:0]   tx_cnt,    tx_cnt_nxt;
    logic [IDX_W-1:0]       tx_idx,    tx_idx_nxt;
    logic [DATA_WIDTH-1:0]  tx_shift,  tx_shift_nxt;
    logic                   tx_par,    tx_par_nxt;
    logic                   tx_line,   tx_line_nxt;

    assign tx_ready = (tx_state == TX_IDLE);
    assign uart_tx  = tx_line;

    // TX state, datapath and registered line driver.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_div   <= '0;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            tx_div   <= tx_div_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_idx   <= tx_idx_nxt;
            tx_shift <= tx_shift_nxt;
            tx_par   <= tx_par_nxt;
            tx_line  <= tx_line_nxt;
        end
    end

    // TX next state: each bit is held until the down-counter reaches zero.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_div_nxt   = tx_div;
        tx_cnt_nxt   = (tx_cnt != '0) ? tx_cnt - 1'b1 : tx_cnt;
        tx_idx_nxt   = tx_idx;
        tx_shift_nxt = tx_shift;
        tx_par_nxt   = tx_par;
        tx_line_nxt  = tx_line;
        case (tx_state)
            TX_IDLE: begin
                tx_line_nxt = 1'b1;
                if (tx_valid) begin
                    tx_state_nxt = TX_START;
                    tx_div_nxt   = baud_div;
                    tx_cnt_nxt   = baud_div - 1'b1;
                    tx_idx_nxt   = '0;
                    tx_shift_nxt = tx_data;
                    tx_par_nxt   = (PARITY == PARITY_EVEN) ? ^tx_data : ~^tx_data;
                    tx_line_nxt  = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt == '0) begin
                    tx_state_nxt = TX_DATA;
                    tx_cnt_nxt   = tx_div - 1'b1;
                    tx_idx_nxt   = '0;
                    tx_line_nxt  = tx_shift[0];
                end
            end
            TX_DATA: begin
                if (tx_cnt == '0) begin
                    tx_cnt_nxt = tx_div - 1'b1;
                    if (tx_idx == IDX_W'(DATA_WIDTH - 1)) begin
                        tx_idx_nxt = '0;
                        if (PARITY != PARITY_NONE) begin
                            tx_state_nxt = TX_PARITY;
                            tx_line_nxt  = tx_par;
                        end else begin
                            tx_state_nxt = TX_STOP;
                            tx_line_nxt  = 1'b1;
                        end
                    end else begin
                        tx_idx_nxt   = tx_idx + 1'b1;
                        tx_shift_nxt = tx_shift >> 1;
                        tx_line_nxt  = tx_shift[1];
                    end
                end
            end
            TX_PARITY: begin
                if (tx_cnt == '0) begin
                    tx_state_nxt = TX_STOP;
                    tx_cnt_nxt   = tx_div - 1'b1;
                    tx_idx_nxt   = '0;
                    tx_line_nxt  = 1'b1;
                end
            end
            TX_STOP: begin
                tx_line_nxt = 1'b1;
                if (tx_cnt == '0) begin
                    if (tx_idx == IDX_W'(STOP_BITS - 1)) begin
                        tx_state_nxt = TX_IDLE;
                    end else begin
                        tx_idx_nxt = tx_idx + 1'b1;
                        tx_cnt_nxt = tx_div - 1'b1;
                    end
                end
            end
            default: begin
                tx_state_nxt = TX_IDLE;
                tx_line_nxt  = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_fifo_transceiver.sv
// Directed bench for uart_fifo_transceiver: 8 data bits, even parity,
// one stop bit, 4-entry RX FIFO, baud_div = 16.
module tb_uart_fifo_transceiver;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] baud_div = 16'd16;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_parity_err;
    logic        rx_frame_err;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic        rx_overflow;
    logic [2:0]  rx_count;
    logic        uart_rx;
    logic        uart_tx;
    logic        loop = 1'b0;
    logic        rx_drv = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;
    int ovf_cycles = 0;

    assign uart_rx = loop ? uart_tx : rx_drv;

    always #5 clk = ~clk;

    uart_fifo_transceiver #(
        .DATA_WIDTH    (8),
        .STOP_BITS     (1),
        .PARITY        (PARITY_EVEN),
        .DIV_WIDTH     (16),
        .RX_FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .baud_div      (baud_div),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_data       (rx_data),
        .rx_parity_err (rx_parity_err),
        .rx_frame_err  (rx_frame_err),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_overflow   (rx_overflow),
        .rx_count      (rx_count),
        .uart_rx       (uart_rx),
        .uart_tx       (uart_tx)
    );

    // Count every cycle rx_overflow is high, sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst && rx_overflow) ovf_cycles <= ovf_cycles + 1;
    end

    typedef struct {
        logic       lpbk;
        logic [7:0] data;
        logic       inv_par;
        logic       stop_v;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[5];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one frame on uart_rx; parity is even over d, optionally inverted.
    task automatic send_direct(input logic [7:0] d, input logic inv_par, input logic stop_v);
        rx_drv = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            tick(16);
        end
        rx_drv = (^d) ^ inv_par;
        tick(16);
        rx_drv = stop_v;
        tick(16);
        rx_drv = 1'b1;
        tick(4);
    endtask

    task automatic send_tx(input logic [7:0] d);
        for (int k = 0; k < 400 && !tx_ready; k++) tick(1);
        check("tx_ready_before_send", tx_ready, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
    endtask

    task automatic wait_rx(input string name);
        for (int k = 0; k < 400 && !rx_valid; k++) tick(1);
        check(name, rx_valid, 1);
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    initial begin
        logic [10:0] exp_line;
        logic [7:0]  ovf_words [5];
        int          ovf_start;

        vecs[0] = '{lpbk: 1'b1, data: 8'h00, inv_par: 1'b0, stop_v: 1'b1, exp_data: 8'h00, exp_perr: 1'b0, exp_ferr: 1'b0};
        vecs[1] = '{lpbk: 1'b1, data: 8'hFF, inv_par: 1'b0, stop_v: 1'b1, exp_data: 8'hFF, exp_perr: 1'b0, exp_ferr: 1'b0};
        vecs[2] = '{lpbk: 1'b1, data: 8'hA5, inv_par: 1'b0, stop_v: 1'b1, exp_data: 8'hA5, exp_perr: 1'b0, exp_ferr: 1'b0};
        vecs[3] = '{lpbk: 1'b0, data: 8'h3C, inv_par: 1'b1, stop_v: 1'b1, exp_data: 8'h3C, exp_perr: 1'b1, exp_ferr: 1'b0};
        vecs[4] = '{lpbk: 1'b0, data: 8'h3C, inv_par: 1'b0, stop_v: 1'b0, exp_data: 8'h3C, exp_perr: 1'b0, exp_ferr: 1'b1};

        // Line pattern of 0x41 with even parity: start, 1000_0010, parity 0, stop.
        exp_line = {1'b1, 1'b0, 8'h41, 1'b0};
        ovf_words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        // Reset state
        tick(3);
        check("rst_uart_tx", uart_tx, 1);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_count", rx_count, 0);
        check("rst_rx_overflow", rx_overflow, 0);
        rst = 1'b0;
        tick(2);

        // TX frame shape and timing for 0x41
        check("tx_idle_ready", tx_ready, 1);
        tx_data  = 8'h41;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tx_data  = 8'hFF;
        check("tx_ready_fall", tx_ready, 0);
        for (int c = 0; c < 176; c++) begin
            check($sformatf("tx_line_c%0d", c), uart_tx, exp_line[c / 16]);
            if (c == 175) check("tx_ready_last_stop", tx_ready, 0);
            tick(1);
        end
        check("tx_ready_return", tx_ready, 1);
        check("tx_line_idle", uart_tx, 1);
        tick(4);

        // Table: loopback words and corrupted direct frames
        for (int v = 0; v < 5; v++) begin
            loop = vecs[v].lpbk;
            if (vecs[v].lpbk) send_tx(vecs[v].data);
            else send_direct(vecs[v].data, vecs[v].inv_par, vecs[v].stop_v);
            wait_rx($sformatf("vec%0d_valid", v));
            check($sformatf("vec%0d_data", v), rx_data, vecs[v].exp_data);
            check($sformatf("vec%0d_perr", v), rx_parity_err, vecs[v].exp_perr);
            check($sformatf("vec%0d_ferr", v), rx_frame_err, vecs[v].exp_ferr);
            check($sformatf("vec%0d_count", v), rx_count, 1);
            pop_one();
            check($sformatf("vec%0d_count_after_pop", v), rx_count, 0);
            tick(40);
            check($sformatf("vec%0d_no_extra", v), rx_count, 0);
        end
        loop = 1'b0;

        // Start-bit glitch of 3 cycles
        rx_drv = 1'b0;
        tick(3);
        rx_drv = 1'b1;
        tick(40);
        check("glitch_count", rx_count, 0);
        check("glitch_valid", rx_valid, 0);

        // Overflow: five words into a four-entry FIFO, no pops
        ovf_start = ovf_cycles;
        for (int w = 0; w < 5; w++) begin
            send_direct(ovf_words[w], 1'b0, 1'b1);
            tick(4);
        end
        check("ovf_count", rx_count, 4);
        check("ovf_pulse_cycles", ovf_cycles - ovf_start, 1);
        for (int w = 0; w < 4; w++) begin
            check($sformatf("ovf_pop%0d_data", w), rx_data, ovf_words[w]);
            check($sformatf("ovf_pop%0d_perr", w), rx_parity_err, 0);
            pop_one();
        end
        check("ovf_drained", rx_count, 0);
        check("ovf_valid_low", rx_valid, 0);

        // Reset mid-frame on both directions with a word in the FIFO
        send_direct(8'h77, 1'b0, 1'b1);
        check("pre_rst_count", rx_count, 1);
        loop = 1'b1;
        send_tx(8'hC3);
        tick(60);
        rst = 1'b1;
        tick(1);
        check("midrst_uart_tx", uart_tx, 1);
        check("midrst_tx_ready", tx_ready, 1);
        check("midrst_rx_count", rx_count, 0);
        check("midrst_rx_valid", rx_valid, 0);
        rst = 1'b0;
        tick(5);
        send_tx(8'h5A);
        wait_rx("post_rst_valid");
        check("post_rst_data", rx_data, 8'h5A);
        check("post_rst_perr", rx_parity_err, 0);
        check("post_rst_ferr", rx_frame_err, 0);
        check("post_rst_count", rx_count, 1);
        pop_one();
        tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_fifo_transceiver.md
# uart_fifo_transceiver

Parametrised full-duplex UART for the z1top designs: a run-time baud divisor, configurable data width, stop bits and parity, and a buffered receive path. The receiver synchronises the line and rejects start-bit glitches. It flags parity and framing errors per word and buffers words in a first-word-fall-through FIFO. The transmitter serialises one word per ready/valid handshake. The block sits between the board UART pins and the application logic.

## Interface
- DATA_WIDTH, 8: data bits per frame, 5..9.
- STOP_BITS, 1: 1 or 2.
- PARITY, 0: 0 none, 1 odd, 2 even (uart_pkg encoding).
- DIV_WIDTH, 16: width of baud_div.
- RX_FIFO_DEPTH, 8: RX FIFO entries; power of 2, at least 2.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- baud_div  in  DIV_WIDTH  clk cycles per bit, at least 4; captured at each frame start.
- tx_data  in  DATA_WIDTH  word to send.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  transmitter idle; a word is accepted on tx_valid && tx_ready.
- rx_data  out  DATA_WIDTH  FIFO head.
- rx_parity_err  out  1  parity error flag of the head word.
- rx_frame_err  out  1  framing error flag of the head word (a stop bit sampled as 0).
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  pops the head when rx_valid && rx_ready.
- rx_overflow  out  1  one-cycle pulse when a received word is dropped.
- rx_count  out  $clog2(RX_FIFO_DEPTH)+1  FIFO occupancy.
- uart_rx  in  1  serial input; asynchronous.
- uart_tx  out  1  serial output.

## Operation
- Reset values: uart_tx=1, tx_ready=1, rx_valid=0, rx_count=0, rx_overflow=0, flags 0. Both synchroniser flops reset to 1. Reset mid-frame aborts both frames and flushes the FIFO.
- Frame format, on the line: start bit (0), data bits LSB first, optional parity bit, STOP_BITS stop bits (1).
- Parity bit: even = ^data; odd = ~^data.
- RX state machine: IDLE -> START -> DATA -> PARITY (skipped when PARITY=0) -> STOP -> IDLE.
  - IDLE: a synchronised 0 enters START and captures baud_div as div.
  - START: after floor(div/2) cycles, re-sample. A 1 is a glitch: return to IDLE and push nothing.
  - DATA, PARITY, STOP: sample every div cycles.
  - Framing error: any stop sample equal to 0.
  - After the last stop sample: push {frame_err, parity_err, data} and go to IDLE in the same cycle, so a start bit that immediately follows is detected.
- FIFO push: succeeds when not full, or when full with a pop in the same cycle.
  - Otherwise the word is dropped, rx_overflow pulses, and FIFO contents are unchanged.
  - Simultaneous push and pop leaves rx_count unchanged.
- TX state machine: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
  - On the accept edge: latch tx_data and baud_div; tx_ready falls.
  - Each bit holds uart_tx for exactly div cycles.
  - After the final stop period, return to IDLE with uart_tx=1 and tx_ready=1.
- tx_data and baud_div changes during a frame have no effect on that frame.

## Timing
- TX:
  - uart_tx falls on the cycle after the accept edge.
  - A frame occupies exactly (1+DATA_WIDTH+(PARITY!=0)+STOP_BITS)*div cycles.
  - With tx_valid held high, at least 1 idle cycle separates frames.
- RX:
  - Synchroniser latency is 2 cycles.
  - Sample k (k=0 for the start bit) is taken floor(div/2)+k*div cycles after IDLE detects the 0.
  - rx_valid rises 1 cycle after the push, and rx_data is stable while rx_valid=1 and no pop occurs.
- rx_overflow is high for exactly the cycle of the failed push.
- rx_count updates in the cycle after the push or pop.

## Structure
- uart_pkg holds:
  - parity encoding constants PARITY_NONE/ODD/EVEN;
  - RX and TX state enums;
  - a FRAME_BITS(width, parity, stops) constant function.
- Sub-module uart_sync_fifo: a parametrised width/depth FWFT FIFO with count, full and empty.
- The RX FSM, TX FSM and synchroniser stay in the top module.

## Test plan
- baud_div=16, PARITY=2: send 0x41 -> uart_tx shows 0, 1000_0010 (LSB first), parity 0, stop 1; 11*16=176 cycles low-to-idle; tx_ready returns after 176 cycles.
- Loop uart_tx to uart_rx and send 0x00, 0xFF, 0xA5 -> rx_data yields the same three words in order, with both error flags 0.
- Drive a 0x3C frame with the parity bit inverted, then one with stop=0 -> head flags are parity_err=1, then frame_err=1; data is still 0x3C.
- Drive a 3-cycle low pulse on uart_rx with baud_div=16 -> no push; rx_count stays 0.
- RX_FIFO_DEPTH=4, rx_ready=0, receive 5 words -> rx_count=4; rx_overflow pulses once on word 5; popping returns words 1-4.
- Assert rst mid-TX frame and mid-RX frame -> uart_tx=1 and tx_ready=1 the next cycle; rx_count=0; a subsequent frame is received correctly.
